// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared FSM states and widths for the pipeline sequencing controller
package hazard_stall_ctrl_pkg;
   typedef enum logic {HZ_RUN = 1'b0, HZ_MD_WAIT = 1'b1} hz_state_t;
   localparam int CNT_WIDTH = 4;
   localparam int MULDIV_LATENCY_DEF = 4;
   localparam int PERF_CNT_WIDTH = 32;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard inputs from ID/EX and pipeline enable/flush controls
interface hazard_stall_ctrl_if #(parameter int REG_ADDR_WIDTH = 5);
   logic [REG_ADDR_WIDTH-1:0] ID_rs1;
   logic [REG_ADDR_WIDTH-1:0] ID_rs2;
   logic [REG_ADDR_WIDTH-1:0] ID_EX_rd;
   logic ID_uses_rs1;
   logic ID_uses_rs2;
   logic ID_EX_MemRead;
   logic ID_EX_muldiv;
   logic EX_branch_taken;
   logic PC_write;
   logic IF_ID_write;
   logic IF_ID_flush;
   logic ID_EX_write;
   logic ID_EX_flush;
   logic EX_MEM_bubble;
   logic muldiv_busy;
   modport master (
      output ID_rs1, ID_rs2, ID_EX_rd, ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead, ID_EX_muldiv, EX_branch_taken,
      input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_bubble, muldiv_busy
   );
   modport slave (
      input  ID_rs1, ID_rs2, ID_EX_rd, ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead, ID_EX_muldiv, EX_branch_taken,
      output PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_bubble, muldiv_busy
   );
endinterface

// File: rtl/hazard_stall_ctrl_perf_cnt.sv
// hazard_perf_cnt: free-running stall-cycle and flush-event counters (HAZARD_PERF_CNT_EN builds only)
module hazard_perf_cnt
   import hazard_stall_ctrl_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      stall,
   input  logic                      flush,
   output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
   output logic [PERF_CNT_WIDTH-1:0] flush_events
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         stall_cycles <= stall_cycles + PERF_CNT_WIDTH'(stall);
         flush_events <= flush_events + PERF_CNT_WIDTH'(flush);
      end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble, taken-branch flush and counted mul/div freeze for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles/flush_events counters.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hazard_stall_ctrl_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
   output logic [PERF_CNT_WIDTH-1:0] flush_events
`endif
);
   hz_state_t state, state_n;
   logic [CNT_WIDTH-1:0] cnt, cnt_n;
   logic [REG_ADDR_WIDTH-1:0] rd;
   logic run, wait_st, load_use, md_start, br, lu, freeze;
   assign rd = hz.ID_EX_rd;
   assign load_use = hz.ID_EX_MemRead && rd != '0 &&
                     ((hz.ID_uses_rs1 && rd == hz.ID_rs1) || (hz.ID_uses_rs2 && rd == hz.ID_rs2));
   // Everything is gated by rst_n so outputs take their reset values combinationally.
   assign run      = rst_n && state == HZ_RUN;
   assign wait_st  = rst_n && state == HZ_MD_WAIT;
   assign md_start = run && hz.ID_EX_muldiv;
   assign br       = run && !hz.ID_EX_muldiv && hz.EX_branch_taken;
   assign lu       = run && !hz.ID_EX_muldiv && !hz.EX_branch_taken && load_use;
   assign freeze   = md_start || (wait_st && cnt != '0);
   assign hz.PC_write      = !(freeze || lu);
   assign hz.IF_ID_write   = !(freeze || lu);
   assign hz.ID_EX_write   = !freeze;
   assign hz.IF_ID_flush   = br;
   assign hz.ID_EX_flush   = br || lu;
   assign hz.EX_MEM_bubble = freeze;
   assign hz.muldiv_busy   = wait_st;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= HZ_RUN;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   // The release cycle (MD_WAIT, cnt==0) returns to RUN without re-arming on the same instruction.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (md_start) begin
         state_n = HZ_MD_WAIT;
         cnt_n   = CNT_WIDTH'(MULDIV_LATENCY - 2);
      end else if (state == HZ_MD_WAIT) begin
         state_n = cnt == '0 ? HZ_RUN : HZ_MD_WAIT;
         cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
      end
   end
`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_cnt u_perf (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (!hz.PC_write),
      .flush        (hz.IF_ID_flush),
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
   );
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of load-use, branch, mul/div freeze and reset behaviour
module tb_hazard_stall_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int pass_cnt = 0;
   int total = 0;
   hazard_stall_ctrl_if #(.REG_ADDR_WIDTH(5)) bus ();
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_events;
`endif
   hazard_stall_ctrl #(.REG_ADDR_WIDTH(5), .MULDIV_LATENCY(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (bus.slave)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
`endif
   );
   always #5 clk = ~clk;
   // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_bubble, muldiv_busy}
   logic [6:0] obs;
   assign obs = {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_write,
                 bus.ID_EX_flush, bus.EX_MEM_bubble, bus.muldiv_busy};
   localparam logic [6:0] DEF  = 7'b1101000;
   localparam logic [6:0] LU   = 7'b0001100;
   localparam logic [6:0] BR   = 7'b1111100;
   localparam logic [6:0] FRZ  = 7'b0000010;
   localparam logic [6:0] BUSY = 7'b0000011;
   localparam logic [6:0] REL  = 7'b1101001;
   task automatic chk(input string tag, input logic [6:0] exp);
      #1;
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      @(negedge clk);
   endtask
`ifdef HAZARD_PERF_CNT_EN
   task automatic pchk(input string tag, input logic [31:0] es, input logic [31:0] ef);
      #1;
      total++;
      assert (stall_cycles === es && flush_events === ef) pass_cnt++;
      else $error("FAIL %s: observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
                  tag, stall_cycles, flush_events, es, ef);
   endtask
`endif
   task automatic clr();
      bus.ID_rs1 = '0; bus.ID_rs2 = '0; bus.ID_EX_rd = '0;
      bus.ID_uses_rs1 = 1'b0; bus.ID_uses_rs2 = 1'b0; bus.ID_EX_MemRead = 1'b0;
      bus.ID_EX_muldiv = 1'b0; bus.EX_branch_taken = 1'b0;
   endtask
   task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
      bus.ID_EX_MemRead = 1'b1; bus.ID_EX_rd = rd; bus.ID_rs1 = rs1; bus.ID_rs2 = rs2;
      bus.ID_uses_rs1 = u1; bus.ID_uses_rs2 = u2;
   endtask
   initial begin
      clr();
      bus.ID_EX_muldiv = 1'b1;
      bus.EX_branch_taken = 1'b1;
      set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      chk("reset_mask", DEF);
      clr();
      rst_n = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
      pchk("perf_reset", 32'd0, 32'd0);
`endif
      chk("idle", DEF);
      set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      chk("lu_stall", LU);
      clr();
      chk("lu_drop", DEF);
      bus.EX_branch_taken = 1'b1;
      chk("branch", BR);
      bus.EX_branch_taken = 1'b0;
      chk("branch_off", DEF);
      bus.ID_EX_muldiv = 1'b1;
      chk("md_start", FRZ);
      bus.ID_EX_muldiv = 1'b0;
      chk("md_w1", BUSY);
      chk("md_w2", BUSY);
      chk("md_rel", REL);
`ifdef HAZARD_PERF_CNT_EN
      pchk("perf_scenario", 32'd4, 32'd1);
`endif
      chk("md_run", DEF);
      set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      chk("lu_x0", DEF);
      set_lu(5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
      chk("lu_rs2_unused", DEF);
      set_lu(5'd7, 5'd3, 5'd7, 1'b0, 1'b1);
      chk("lu_rs2_used", LU);
      set_lu(5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
      chk("lu_no_uses", DEF);
      bus.ID_EX_MemRead = 1'b0; bus.ID_uses_rs1 = 1'b1;
      chk("no_load", DEF);
      set_lu(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
      bus.EX_branch_taken = 1'b1;
      chk("prio_br_over_lu", BR);
      bus.ID_EX_muldiv = 1'b1;
      chk("prio_md", FRZ);
      clr();
      chk("prio_md_w1", BUSY);
      chk("prio_md_w2", BUSY);
      chk("prio_md_rel", REL);
      bus.ID_EX_muldiv = 1'b1;
      chk("md2_start", FRZ);
      bus.EX_branch_taken = 1'b1;
      chk("md2_w1_ign_br", BUSY);
      bus.EX_branch_taken = 1'b0;
      chk("md2_w2", BUSY);
      chk("md2_rel_held", REL);
      chk("md3_b2b_start", FRZ);
      bus.ID_EX_muldiv = 1'b0;
      chk("md3_w1", BUSY);
      chk("md3_w2", BUSY);
      chk("md3_rel", REL);
      chk("md3_run", DEF);
      bus.ID_EX_muldiv = 1'b1;
      chk("rf_start", FRZ);
      bus.ID_EX_muldiv = 1'b0;
      chk("rf_w1", BUSY);
      rst_n = 1'b0;
      chk("rf_reset", DEF);
      rst_n = 1'b1;
      chk("rf_after1", DEF);
      chk("rf_after2", DEF);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
